// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable sequencer for the single-cycle MIPS core.
// Issues one-cycle cpu_ce pulses in RUN every DIVISOR clocks, single steps from
// a debounced push button in HALT, and freezes in STOPPED on a core halt request.
// Drives a 50% LED square wave on clk_out while running.
// Optional feature macro: CPU_CLK_CTRL_CYCLE_COUNT_EN builds the cpu_ce pulse
// counter behind cycle_count; without it cycle_count is constant zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HALT    | idle; a step-button press yields exactly one cpu_ce pulse
// RUN     | free-running; cpu_ce every DIVISOR cycles, clk_out toggling
// STOPPED | halted by the core; ignores steps until run_sw is cleared

module cpu_clk_ctrl #(
  parameter logic [27:0] DIVISOR  = 28'd500_000,
  parameter logic [19:0] DEBOUNCE = 20'd500_000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic        clk_out,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    HALT    = 2'b00,
    RUN     = 2'b01,
    STOPPED = 2'b10
  } state_t;

  localparam logic [27:0] DIV_LAST = DIVISOR - 28'd1;
  localparam logic [27:0] DIV_HALF = DIVISOR >> 1;
  localparam logic [19:0] DB_LAST  = DEBOUNCE - 20'd1;

  logic        run_s1, run_s2;
  logic        btn_s1, btn_s2;
  logic        btn_db, btn_db_d;
  logic [19:0] db_cnt;
  logic [27:0] div_cnt;
  logic [27:0] div_nxt;
  state_t      st;
  logic        step_evt;
  logic        term_cnt;
  logic        ce_set;

  // Two-flop synchronizers for the asynchronous switch and button
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s2 <= run_s1;
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept the new button level only after DEBOUNCE disagreeing samples
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign step_evt = btn_db & ~btn_db_d;
  assign term_cnt = (div_cnt == DIV_LAST);
  assign div_nxt  = term_cnt ? 28'd0 : div_cnt + 28'd1;

  // A pulse is due on a HALT step, or on terminal count while RUN stays selected;
  // leaving RUN through run_sw suppresses it, a halt request does not.
  assign ce_set = ((st == HALT) & step_evt) | ((st == RUN) & run_s2 & term_cnt);

  // Sequencing FSM with registered cpu_ce, clk_out and divider
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st      <= HALT;
      div_cnt <= '0;
      cpu_ce  <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cpu_ce <= ce_set;
      case (st)
        HALT: begin
          if (run_s2) begin
            st      <= RUN;
            div_cnt <= '0;
            // div_cnt restarts at 0, which is always in the high half for DIVISOR >= 2
            clk_out <= 1'b1;
          end else begin
            clk_out <= 1'b0;
          end
        end
        RUN: begin
          if (!run_s2) begin
            st      <= HALT;
            div_cnt <= '0;
            clk_out <= 1'b0;
          end else if (halt_req) begin
            st      <= STOPPED;
            div_cnt <= '0;
            clk_out <= 1'b0;
          end else begin
            div_cnt <= div_nxt;
            clk_out <= (div_nxt < DIV_HALF);
          end
        end
        STOPPED: begin
          clk_out <= 1'b0;
          if (!run_s2) begin
            st <= HALT;
          end
        end
        default: begin
          st      <= HALT;
          div_cnt <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
  logic [31:0] ce_cnt;

  // Count issued pulses; lands in the same cycle as the pulse it counts
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt <= '0;
    end else if (ce_set) begin
      ce_cnt <= ce_cnt + 32'd1;
    end
  end

  assign cycle_count = ce_cnt;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl with DIVISOR=4, DEBOUNCE=3.
// A behavioural model (RUN phase as age modulo DIVISOR, pulse tally) is compared
// against the DUT on every falling edge; directed scenarios add literal checks.

module tb_cpu_clk_ctrl;

  localparam int D   = 4;
  localparam int DEB = 3;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_ce;
  logic        clk_out;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;

  cpu_clk_ctrl #(.DIVISOR(28'd4), .DEBOUNCE(20'd3)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .cpu_ce      (cpu_ce),
    .clk_out     (clk_out),
    .state       (state),
    .cycle_count (cycle_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_state;
  int         age;
  int         npulse;
  logic       r_a, r_b, b_a, b_b, db, db_prev;
  int         dlen;
  logic       e_ce, e_clk;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 2'd0; age = 0; npulse = 0;
      r_a = 0; r_b = 0; b_a = 0; b_b = 0; db = 0; db_prev = 0; dlen = 0;
      e_ce = 0; e_clk = 0;
    end else begin
      e_ce = 0;
      case (m_state)
        2'd0: begin
          e_clk = 0;
          if (db && !db_prev) e_ce = 1;
          if (r_b) begin m_state = 2'd1; age = 0; e_clk = 1; end
        end
        2'd1: begin
          if (!r_b) begin
            m_state = 2'd0; e_clk = 0;
          end else begin
            if ((age + 1) % D == 0) e_ce = 1;
            if (halt_req) begin
              m_state = 2'd2; e_clk = 0;
            end else begin
              age++;
              e_clk = ((age % D) < (D / 2));
            end
          end
        end
        default: begin
          e_clk = 0;
          if (!r_b) m_state = 2'd0;
        end
      endcase
      if (e_ce) npulse++;
      db_prev = db;
      if (b_b != db) begin
        dlen++;
        if (dlen == DEB) begin db = b_b; dlen = 0; end
      end else begin
        dlen = 0;
      end
      r_b = r_a; r_a = run_sw;
      b_b = b_a; b_a = step_btn;
    end
  end

  function automatic logic [31:0] exp_count();
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    return 32'(npulse);
`else
    return 32'd0;
`endif
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk_in) begin
    check("cmp_ce",    {31'd0, cpu_ce},  {31'd0, e_ce});
    check("cmp_clk",   {31'd0, clk_out}, {31'd0, e_clk});
    check("cmp_state", {30'd0, state},   {30'd0, m_state});
    check("cmp_count", cycle_count,      exp_count());
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  int seen;
  logic found;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ce", {31'd0, cpu_ce}, 32'd0);
    check("rst_clk", {31'd0, clk_out}, 32'd0);
    check("rst_count", cycle_count, 32'd0);

    // RUN entry and pulse cadence
    run_sw = 1'b1;
    tick(); tick();
    check("run_lat_halt", {30'd0, state}, 32'd0);
    tick();
    check("run_lat_run", {30'd0, state}, 32'd1);
    check("run_k0_clk", {31'd0, clk_out}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("run_ce", {31'd0, cpu_ce}, (k % 4 == 0) ? 32'd1 : 32'd0);
      check("run_clk", {31'd0, clk_out}, (k % 4 < 2) ? 32'd1 : 32'd0);
    end
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    check("run_count3", cycle_count, 32'd3);
`else
    check("run_count0", cycle_count, 32'd0);
`endif

    // halt_req on terminal count
    tick(); tick(); tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_ce", {31'd0, cpu_ce}, 32'd1);
    check("halt_state", {30'd0, state}, 32'd2);
    check("halt_clk", {31'd0, clk_out}, 32'd0);

    // steps ignored in STOPPED
    seen = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (cpu_ce) seen++; end
    step_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (cpu_ce) seen++; end
    check("stop_no_ce", 32'(seen), 32'd0);
    check("stop_state", {30'd0, state}, 32'd2);

    run_sw = 1'b0;
    tick(); tick();
    check("stop_hold", {30'd0, state}, 32'd2);
    tick();
    check("stop_to_halt", {30'd0, state}, 32'd0);

    run_sw = 1'b1;
    tick(); tick(); tick();
    check("rerun_state", {30'd0, state}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rerun_ce", {31'd0, cpu_ce}, (k == 4) ? 32'd1 : 32'd0);
    end

    // run_sw falls so the exit lands on terminal count
    tick();
    run_sw = 1'b0;
    tick(); tick(); tick();
    check("exit_state", {30'd0, state}, 32'd0);
    check("exit_ce", {31'd0, cpu_ce}, 32'd0);
    check("exit_clk", {31'd0, clk_out}, 32'd0);
    tick(); tick();

    // single step from HALT, button held 10 cycles
    step_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 11) step_btn = 1'b0;
      tick();
      check("step_ce", {31'd0, cpu_ce}, (i == 6) ? 32'd1 : 32'd0);
    end
    step_btn = 1'b0;
    repeat (10) tick();

    // 2-cycle glitch gives nothing
    seen = 0;
    step_btn = 1'b1;
    tick(); tick();
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (cpu_ce) seen++; end
    check("glitch_no_ce", 32'(seen), 32'd0);

    // asynchronous reset during a pulse
    run_sw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (cpu_ce) found = 1'b1;
    end
    if (!found) begin
      errors++; checks++;
      $display("FAIL wait_ce: no pulse within 30 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_ce", {31'd0, cpu_ce}, 32'd0);
    check("arst_clk", {31'd0, clk_out}, 32'd0);
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_count", cycle_count, 32'd0);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_state", {30'd0, state}, 32'd0);
    repeat (6) tick();
    check("post_rst_run", {30'd0, state}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Processor clock-enable controller for the single-cycle MIPS core on the 50 MHz FPGA board. It replaces free-running divided clocking with a sequenced `cpu_ce` pulse, so the core can be in one of three conditions: run continuously at `clk_in/DIVISOR`, be single-stepped from a push button, or be stopped by a halt request from the core. It also produces a 50 % square wave `clk_out` for the board LED.

## Interface
- `DIVISOR`, default 28'd500_000: `clk_in` cycles per `cpu_ce` pulse in RUN; legal range is 2 or more.
- `DEBOUNCE`, default 20'd500_000: number of consecutive stable synchronized samples required before the step-button level is accepted; legal range is 1 or more.
- `clk_in`  input  1  system clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run_sw`  input  1  raw slide switch; 1 requests RUN.
- `step_btn`  input  1  raw push button; each press gives one step.
- `halt_req`  input  1  synchronous to `clk_in` (from the core, e.g. on a syscall/break decode).
- `cpu_ce`  output  1  one-cycle core clock-enable pulse.
- `clk_out`  output  1  divided square wave for the LED; low when not in RUN.
- `state`  output  2  encoding: 2'b00 HALT, 2'b01 RUN, 2'b10 STOPPED.
- `cycle_count`  output  32  number of `cpu_ce` pulses issued (see Configuration).

## Operation
- `run_sw` and `step_btn` each pass through a 2-flop synchronizer.
- `step_btn` is additionally debounced. The debounced level `btn_db` toggles only after the synchronized level has differed from `btn_db` for `DEBOUNCE` consecutive cycles. The debounce counter clears whenever the two levels agree.
- A step event is the rising edge of `btn_db`.
- All outputs are registered. Reset values: `cpu_ce`=0, `clk_out`=0, `state`=HALT, `cycle_count`=0. The divider counter `div_cnt`, `btn_db`, the debounce counter and the synchronizers are also cleared to 0.

**State machine**
- HALT -> RUN when synchronized `run_sw`=1. `div_cnt` is cleared on entry.
- HALT: a step event produces exactly one `cpu_ce` pulse in the following cycle. `state` remains HALT.
- RUN: `div_cnt` counts 0..`DIVISOR`-1 and wraps to 0.
  - `cpu_ce`=1 in the cycle after `div_cnt`==`DIVISOR`-1.
  - `clk_out` is 1 while `div_cnt` < `DIVISOR`/2 (integer division), otherwise 0.
- RUN -> HALT when synchronized `run_sw`=0. `div_cnt` is cleared and no further pulses are issued.
- RUN -> STOPPED when `halt_req`=1. `halt_req` is sampled only in RUN.
- STOPPED -> HALT when synchronized `run_sw`=0. STOPPED never returns directly to RUN; the switch must be cycled.
- STOPPED: step events are ignored, `cpu_ce`=0 and `clk_out`=0.
- Step events in RUN are ignored and are not queued.

**Boundary rules**
- `halt_req` in the same cycle as terminal count: the pending `cpu_ce` pulse is still issued, then the block enters STOPPED.
- `run_sw` falling in the same cycle as terminal count: the pulse is suppressed, because the state-exit takes priority.
- `run_sw`=0 together with `halt_req`=1 in RUN: the next state is HALT.
- Button held down: one step only. A new step requires `btn_db` to fall and rise again.
- Reset mid-pulse: `cpu_ce` drops asynchronously. Everything restarts from HALT.

## Timing
- `run_sw` edge to state change: 3 `clk_in` cycles (2 synchronizer stages plus the state register).
- RUN entry to first `cpu_ce`: `DIVISOR` cycles after the first RUN cycle. Thereafter one pulse every `DIVISOR` cycles exactly, with no drift.
- Step latency: a press held stable from cycle t gives `btn_db` rising at t+2+`DEBOUNCE` and `cpu_ce` at t+3+`DEBOUNCE`. Pulse width is always exactly 1 cycle.
- `halt_req` to `state`=STOPPED: 1 cycle.
- `cycle_count` updates in the same cycle as the `cpu_ce` pulse it counts. It wraps modulo 2^32.

## Configuration
- `CPU_CLK_CTRL_CYCLE_COUNT_EN` defined: a 32-bit counter increments on every `cpu_ce` pulse and drives `cycle_count`. The counter clears only on reset.
- Not defined: no counter is built, and `cycle_count` is tied to 32'd0. All other behaviour is identical.

## Test plan
Parameters for all scenarios: `DIVISOR`=4, `DEBOUNCE`=3.
- Reset, then `run_sw`=1 -> state RUN 3 cycles later; `cpu_ce` pulses on cycles +4, +8, +12 of RUN; `clk_out` pattern 1,1,0,0 repeating; with the macro defined `cycle_count`=3 after the third pulse.
- In HALT, press `step_btn` for 10 cycles -> exactly one `cpu_ce`, 6 cycles after press start.
- In HALT, apply a 2-cycle button glitch -> no `cpu_ce`.
- In RUN, assert `halt_req` coincident with terminal count -> `cpu_ce`=1 in the next cycle, `state`=STOPPED. Further step presses produce no `cpu_ce`. Setting `run_sw`=0 gives HALT. Setting `run_sw`=1 again gives RUN with the first pulse 4 cycles later.
- `run_sw` falls timed so the state exits on terminal count -> no pulse, `state`=HALT, `clk_out`=0.
- Assert `rst_n`=0 asynchronously during a `cpu_ce` pulse -> all outputs return to their reset values immediately. Without the macro, `cycle_count` reads 0 throughout.
